pal_fuse_loader: RTL

- Field-programmable counterpart to the team's hard-wired 4-input/5-output PAL decode blocks.
- Accepts a fuse map over a serial valid/ready stream and verifies it with a parity bit.
- Holds the map in a double-buffered register and evaluates the programmed AND-OR array on a registered output.
- Lets the decode equations be replaced at run time without re-synthesis.

---
 rtl/pal_fuse_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pal_fuse_loader.sv
// Field-programmable 4-in/5-out PAL decode block.
//
// A fuse map is shifted in serially over a valid/ready stream, checked
// against a trailing even-parity bit and, if good, committed from a shadow
// register into the active map. The active map drives a programmable
// AND-OR array whose result is registered on out_vec.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   cfg_start    pulse: begin/restart a map load (ignored in CHECK)
//   cfg_valid    cfg_bit carries a fuse or parity bit this cycle
//   cfg_bit      serial fuse/parity bit, fuse index 0 first
//   cfg_ready    loader accepts bits (LOAD state only)
//   cfg_done     one-cycle pulse when a new map is committed
//   cfg_err      sticky parity error, cleared by cfg_start
//   cfg_loaded   an active map exists
//   in_vec       array inputs, in_vec[NIN-1] is A ... in_vec[0] is D
//   out_vec      registered array outputs, out_vec[0] is F1
module pal_fuse_loader #(
    parameter int unsigned NIN  = 4,
    parameter int unsigned NPT  = 15,
    parameter int unsigned NOUT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    output logic            cfg_err,
    output logic            cfg_loaded,
    input  logic [NIN-1:0]  in_vec,
    output logic [NOUT-1:0] out_vec
);

    localparam int unsigned AND_BITS = NPT * 2 * NIN;
    localparam int unsigned NFUSE    = AND_BITS + NOUT * NPT;
    localparam int unsigned CW       = $clog2(NFUSE + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StRun} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             parity_q, parity_d;
    logic [NFUSE-1:0] shadow_q, shadow_d;
    logic [NFUSE-1:0] active_q, active_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             loaded_q, loaded_d;
    logic [NOUT-1:0]  out_q;

    logic             xfer;
    logic [NPT-1:0]   term;
    logic [NOUT-1:0]  eval;

    assign cfg_ready  = (state_q == StLoad);
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign cfg_loaded = loaded_q;
    assign out_vec    = out_q;

    assign xfer = cfg_valid && cfg_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        parity_d = parity_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        err_d    = err_q;
        loaded_d = loaded_q;
        unique case (state_q)
            StIdle, StRun: begin
                if (cfg_start) begin
                    state_d  = StLoad;
                    count_d  = '0;
                    parity_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            StLoad: begin
                // A restart takes priority over a bit arriving the same cycle.
                if (cfg_start) begin
                    count_d  = '0;
                    parity_d = 1'b0;
                    err_d    = 1'b0;
                end else if (xfer) begin
                    parity_d = parity_q ^ cfg_bit;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(NFUSE)) begin
                        state_d = StCheck;
                    end else begin
                        shadow_d[count_q] = cfg_bit;
                    end
                end
            end
            StCheck: begin
                state_d = StRun;
                if (!parity_q) begin
                    active_d = shadow_q;
                    loaded_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // AND plane: an unconnected term is forced low; a term holding both a
    // literal and its complement falls out low naturally.
    always_comb begin
        logic hit;
        term = '0;
        eval = '0;
        for (int p = 0; p < NPT; p++) begin
            hit = |active_q[p*2*NIN +: 2*NIN];
            for (int i = 0; i < NIN; i++) begin
                if (active_q[p*2*NIN + 2*i] && !in_vec[i]) hit = 1'b0;
                if (active_q[p*2*NIN + 2*i + 1] && in_vec[i]) hit = 1'b0;
            end
            term[p] = hit;
        end
        for (int o = 0; o < NOUT; o++) begin
            eval[o] = |(active_q[AND_BITS + o*NPT +: NPT] & term);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            parity_q <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            parity_q <= parity_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            out_q    <= loaded_q ? eval : '0;
        end
    end

endmodule
